// File: rtl/gbm_path_sequencer.sv
// Drives one Monte-Carlo GBM price path: fetch z, issue a step, capture S_next, emit the sample.
// Optional antithetic rerun from s0 with negated variates: define GBM_PATH_SEQ_ANTITHETIC_EN.
//
// state | meaning
// IDLE  | waiting for start; parameters latched on start
// FETCH | z_ready high, waiting for one normal variate
// ISSUE | gbm_valid high, operands held until gbm_ready
// WAIT  | res_ready high, waiting for S_next from GBM
// EMIT  | out_valid high, sample held until out_ready
module gbm_path_sequencer #(
  parameter int WIDTH     = 32,
  parameter int QFRAC     = 16,
  parameter int MAX_STEPS = 256,
  parameter int STEP_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  s0,
  input  logic [WIDTH-1:0]  r_in,
  input  logic [WIDTH-1:0]  sigma_in,
  input  logic [WIDTH-1:0]  dt_in,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              z_valid,
  output logic              z_ready,
  input  logic [WIDTH-1:0]  z_data,
  output logic              gbm_valid,
  input  logic              gbm_ready,
  output logic [WIDTH-1:0]  gbm_z,
  output logic [WIDTH-1:0]  gbm_S,
  output logic [WIDTH-1:0]  gbm_r,
  output logic [WIDTH-1:0]  gbm_sigma,
  output logic [WIDTH-1:0]  gbm_dt,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [WIDTH-1:0]  res_S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_S,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
  output logic              out_anti,
`endif
  output logic              clamp_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_t;

  localparam logic [STEP_W-1:0] MAX_N   = STEP_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0]  ONE_LSB = WIDTH'(1);

  if (QFRAC >= WIDTH) begin : g_bad_qfrac
    $error("QFRAC must be smaller than WIDTH");
  end

  state_t            state, state_n;
  logic [WIDTH-1:0]  s_cur, s_cur_n;
  logic [WIDTH-1:0]  r_q, r_n;
  logic [WIDTH-1:0]  sigma_q, sigma_n;
  logic [WIDTH-1:0]  dt_q, dt_n;
  logic [WIDTH-1:0]  z_q, z_n;
  logic [WIDTH-1:0]  cap_q, cap_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [STEP_W-1:0] nsteps_q, nsteps_n;
  logic [STEP_W-1:0] step_inc;
  logic [STEP_W-1:0] nsteps_req;
  logic              clamp_n;
  logic              last_n;
  logic              done_n;
  logic              z_ready_n;
  logic              gbm_valid_n;
  logic              res_ready_n;
  logic              out_valid_n;
  logic              busy_n;
  logic              res_nonpos;

  assign gbm_S     = s_cur;
  assign gbm_z     = z_q;
  assign gbm_r     = r_q;
  assign gbm_sigma = sigma_q;
  assign gbm_dt    = dt_q;
  assign out_S     = cap_q;
  assign out_step  = step_q;

  assign step_inc   = step_q + STEP_W'(1);
  assign nsteps_req = (num_steps > MAX_N) ? MAX_N : num_steps;
  assign res_nonpos = res_S[WIDTH-1] || (res_S == '0);

`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
  localparam int ADDR_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  logic [WIDTH-1:0] zbuf [MAX_STEPS];
  logic [WIDTH-1:0] s0_q, s0_n;
  logic             anti_n;
  logic             zbuf_we;

  // Mirror variate; the most negative code has no positive twin, so saturate it.
  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (v == {1'b1, {(WIDTH-1){1'b0}}}) res = {1'b0, {(WIDTH-1){1'b1}}};
    else                                res = -v;
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (zbuf_we) zbuf[ADDR_W'(step_q)] <= z_data;
  end
`endif

  always_comb begin
    state_n  = state;
    s_cur_n  = s_cur;
    r_n      = r_q;
    sigma_n  = sigma_q;
    dt_n     = dt_q;
    z_n      = z_q;
    cap_n    = cap_q;
    step_n   = step_q;
    nsteps_n = nsteps_q;
    clamp_n  = clamp_flag;
    last_n   = out_last;
    done_n   = 1'b0;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
    s0_n    = s0_q;
    anti_n  = out_anti;
    zbuf_we = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          s_cur_n  = s0;
          r_n      = r_in;
          sigma_n  = sigma_in;
          dt_n     = dt_in;
          nsteps_n = nsteps_req;
          step_n   = '0;
          clamp_n  = 1'b0;
          last_n   = 1'b0;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
          s0_n   = s0;
          anti_n = 1'b0;
`endif
          // An empty path completes immediately without touching the z stream.
          if (nsteps_req == '0) done_n  = 1'b1;
          else                  state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        if (z_valid && z_ready) begin
          z_n     = z_data;
          state_n = S_ISSUE;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
          zbuf_we = 1'b1;
`endif
        end
      end

      S_ISSUE: begin
        if (gbm_valid && gbm_ready) state_n = S_WAIT;
      end

      S_WAIT: begin
        if (res_valid && res_ready) begin
          if (res_nonpos) begin
            cap_n   = ONE_LSB;
            clamp_n = 1'b1;
          end else begin
            cap_n = res_S;
          end
          last_n  = (step_q == nsteps_q - STEP_W'(1));
          state_n = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_valid && out_ready) begin
          s_cur_n = cap_q;
          if (out_last) begin
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
            if (!out_anti) begin
              anti_n  = 1'b1;
              step_n  = '0;
              s_cur_n = s0_q;
              z_n     = neg_sat(zbuf[0]);
              state_n = S_ISSUE;
            end else begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
`else
            done_n  = 1'b1;
            state_n = S_IDLE;
`endif
          end else begin
            step_n = step_inc;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
            if (out_anti) begin
              z_n     = neg_sat(zbuf[ADDR_W'(step_inc)]);
              state_n = S_ISSUE;
            end else begin
              state_n = S_FETCH;
            end
`else
            state_n = S_FETCH;
`endif
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    z_ready_n   = (state_n == S_FETCH);
    gbm_valid_n = (state_n == S_ISSUE);
    res_ready_n = (state_n == S_WAIT);
    out_valid_n = (state_n == S_EMIT);
    busy_n      = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      s_cur      <= '0;
      r_q        <= '0;
      sigma_q    <= '0;
      dt_q       <= '0;
      z_q        <= '0;
      cap_q      <= '0;
      step_q     <= '0;
      nsteps_q   <= '0;
      clamp_flag <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      z_ready    <= 1'b0;
      gbm_valid  <= 1'b0;
      res_ready  <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
      s0_q       <= '0;
      out_anti   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      s_cur      <= s_cur_n;
      r_q        <= r_n;
      sigma_q    <= sigma_n;
      dt_q       <= dt_n;
      z_q        <= z_n;
      cap_q      <= cap_n;
      step_q     <= step_n;
      nsteps_q   <= nsteps_n;
      clamp_flag <= clamp_n;
      out_last   <= last_n;
      done       <= done_n;
      z_ready    <= z_ready_n;
      gbm_valid  <= gbm_valid_n;
      res_ready  <= res_ready_n;
      out_valid  <= out_valid_n;
      busy       <= busy_n;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
      s0_q       <= s0_n;
      out_anti   <= anti_n;
`endif
    end
  end

endmodule

// File: tb/tb_gbm_path_sequencer.sv
// Bench for gbm_path_sequencer: randomized z/GBM/store stalls checked against a path-level model.
module tb_gbm_path_sequencer;
  localparam int MAX_STEPS = 256;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s0 = '0, r_in = '0, sigma_in = '0, dt_in = '0;
  logic [8:0]  num_steps = '0;
  logic        z_valid = 1'b0;
  logic        z_ready;
  logic [31:0] z_data = '0;
  logic        gbm_valid;
  logic        gbm_ready = 1'b1;
  logic [31:0] gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_S = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_S;
  logic [8:0]  out_step;
  logic        out_last, busy, done, clamp_flag;
  logic        anti_bit;
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
  logic        out_anti;
  assign anti_bit = out_anti;
`else
  assign anti_bit = 1'b0;
`endif

  gbm_path_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s0(s0), .r_in(r_in), .sigma_in(sigma_in),
    .dt_in(dt_in), .num_steps(num_steps), .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data),
    .gbm_valid(gbm_valid), .gbm_ready(gbm_ready), .gbm_z(gbm_z), .gbm_S(gbm_S), .gbm_r(gbm_r),
    .gbm_sigma(gbm_sigma), .gbm_dt(gbm_dt), .res_valid(res_valid), .res_ready(res_ready),
    .res_S(res_S), .out_valid(out_valid), .out_ready(out_ready), .out_S(out_S),
    .out_step(out_step), .out_last(out_last), .busy(busy), .done(done),
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
    .out_anti(out_anti),
`endif
    .clamp_flag(clamp_flag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] s, z, r, sg, dt; } issue_t;
  typedef struct { logic [31:0] s; logic [8:0] step; logic last; logic anti; } samp_t;

  int          vectors = 0, miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          stall_pct = 0, force_neg_step = -1, gbm_count = 0, z_hs = 0, done_cnt = 0;
  int unsigned done_cyc = 0, last_hs_cyc = 0, start_cyc = 0;
  bit          saw_z_ready = 0, saw_out_valid = 0;
  logic [31:0] z_q[$], z_ref[$];
  issue_t      iss_q[$], exp_iss[$];
  samp_t       smp_q[$], exp_smp[$], basic_smp[$];
  logic [31:0] e_s0, e_r, e_sg, e_dt;
  int          e_n, e_force, e_cap;
  logic        exp_clamp;

  function automatic bit go();
    return $urandom_range(0, 99) >= stall_pct;
  endfunction

  // Stand-in for the GBM stage: any deterministic function of all operands works here.
  function automatic logic [31:0] gbm_fn(logic [31:0] s, z, r, sg, dt);
    return s + z + (r ^ sg) - dt;
  endfunction

  function automatic logic [31:0] neg_sat(logic [31:0] v);
    return (v == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'd0 - v;
  endfunction

  // Upstream variate source
  bit z_hs_now;
  initial forever begin
    @(negedge clk);
    z_hs_now = z_valid && z_ready;
    @(posedge clk); #1;
    if (!rst_n) z_valid = 1'b0;
    else begin
      if (z_hs_now && z_q.size() > 0) begin void'(z_q.pop_front()); z_hs++; end
      if (z_q.size() == 0) begin z_valid = 1'b0; z_data = $urandom; end
      else if (z_valid && !z_hs_now) z_data = z_q[0];
      else if (go()) begin z_valid = 1'b1; z_data = z_q[0]; end
      else begin z_valid = 1'b0; z_data = $urandom; end
    end
  end

  // GBM stage model with random accept/latency, plus operand stability check
  bit          ghs, rhs, g_pend = 0, g_hold = 0;
  int          g_lat = 0;
  logic [31:0] g_res;
  issue_t      g_prev;
  initial forever begin
    @(negedge clk);
    ghs = gbm_valid && gbm_ready;
    rhs = res_valid && res_ready;
    if (gbm_valid) begin
      if (g_hold) begin
        vectors++;
        if ({gbm_S, gbm_z, gbm_r, gbm_sigma, gbm_dt} !==
            {g_prev.s, g_prev.z, g_prev.r, g_prev.sg, g_prev.dt}) begin
          miscompares++;
          $display("FAIL gbm_operand_stable: got S=%h z=%h, held S=%h z=%h",
                   gbm_S, gbm_z, g_prev.s, g_prev.z);
        end
      end
      g_prev = '{gbm_S, gbm_z, gbm_r, gbm_sigma, gbm_dt};
      g_hold = !ghs;
    end else g_hold = 0;
    if (ghs) begin
      iss_q.push_back('{gbm_S, gbm_z, gbm_r, gbm_sigma, gbm_dt});
      g_res = (gbm_count == force_neg_step) ? 32'hFFFF_0000
                                            : gbm_fn(gbm_S, gbm_z, gbm_r, gbm_sigma, gbm_dt);
      gbm_count++;
      g_lat = (stall_pct > 0) ? $urandom_range(0, 3) : 0;
    end
    @(posedge clk); #1;
    if (!rst_n) begin res_valid = 1'b0; g_pend = 0; g_hold = 0; end
    else begin
      if (rhs) begin res_valid = 1'b0; res_S = $urandom; end
      if (ghs) g_pend = 1;
      if (g_pend && !res_valid) begin
        if (g_lat == 0) begin res_valid = 1'b1; res_S = g_res; g_pend = 0; end
        else g_lat--;
      end
      gbm_ready = go();
    end
  end

  // Path store sink and done/z_ready observers
  bit    ohs, o_hold = 0;
  samp_t o_prev;
  initial forever begin
    @(negedge clk);
    ohs = out_valid && out_ready;
    if (z_ready) saw_z_ready = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (out_valid) begin
      saw_out_valid = 1;
      if (o_hold) begin
        vectors++;
        if ({out_S, out_step, out_last, anti_bit} !==
            {o_prev.s, o_prev.step, o_prev.last, o_prev.anti}) begin
          miscompares++;
          $display("FAIL out_stable: got S=%h step=%0d, held S=%h step=%0d",
                   out_S, out_step, o_prev.s, o_prev.step);
        end
      end
      o_prev = '{out_S, out_step, out_last, anti_bit};
      o_hold = !ohs;
    end else o_hold = 0;
    if (ohs) begin
      smp_q.push_back('{out_S, out_step, out_last, anti_bit});
      last_hs_cyc = cyc;
    end
    @(posedge clk); #1;
    if (!rst_n) o_hold = 0;
    out_ready = go();
  end

  task automatic clear_obs();
    smp_q.delete(); iss_q.delete();
    done_cnt = 0; z_hs = 0; gbm_count = 0; saw_z_ready = 0; saw_out_valid = 0;
  endtask

  task automatic pulse_start(logic [31:0] a, b, c, d, int n);
    @(posedge clk); #1;
    s0 = a; r_in = b; sigma_in = c; dt_in = d; num_steps = 9'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Path-level reference: S_{k+1} = max(gbm(S_k, z_k), 1 LSB), optional mirrored second pass
  task automatic build_model();
    logic [31:0] s, zz, res;
    int idx;
    exp_smp.delete(); exp_iss.delete(); exp_clamp = 0; idx = 0;
    e_cap = (e_n > MAX_STEPS) ? MAX_STEPS : e_n;
    for (int p = 0; p < PASSES; p++) begin
      s = e_s0;
      for (int k = 0; k < e_cap; k++) begin
        zz = (p == 0) ? z_ref[k] : neg_sat(z_ref[k]);
        exp_iss.push_back('{s, zz, e_r, e_sg, e_dt});
        res = (idx == e_force) ? 32'hFFFF_0000 : gbm_fn(s, zz, e_r, e_sg, e_dt);
        idx++;
        if ($signed(res) <= 0) begin res = 32'd1; exp_clamp = 1; end
        exp_smp.push_back('{res, 9'(k), (k == e_cap - 1), (p != 0)});
        s = res;
      end
    end
  endtask

  task automatic start_path();
    clear_obs();
    force_neg_step = e_force;
    z_q = z_ref;
    build_model();
    pulse_start(e_s0, e_r, e_sg, e_dt, e_n);
  endtask

  task automatic finish_path(string name);
    int budget = 50 + e_cap * PASSES * 40;
    int waited = 0;
    while (done_cnt == 0 && waited < budget) begin @(posedge clk); waited++; end
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL %s timeout: no done after %0d cycles", name, budget);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (smp_q.size() !== exp_smp.size()) begin
      miscompares++;
      $display("FAIL %s sample_count: got %0d, expected %0d", name, smp_q.size(), exp_smp.size());
    end
    for (int i = 0; i < smp_q.size() && i < exp_smp.size(); i++) begin
      vectors++;
      if ({smp_q[i].s, smp_q[i].step, smp_q[i].last, smp_q[i].anti} !==
          {exp_smp[i].s, exp_smp[i].step, exp_smp[i].last, exp_smp[i].anti}) begin
        miscompares++;
        $display("FAIL %s sample[%0d]: got S=%h step=%0d last=%b anti=%b, expected S=%h step=%0d last=%b anti=%b",
                 name, i, smp_q[i].s, smp_q[i].step, smp_q[i].last, smp_q[i].anti,
                 exp_smp[i].s, exp_smp[i].step, exp_smp[i].last, exp_smp[i].anti);
      end
    end
    vectors++;
    if (iss_q.size() !== exp_iss.size()) begin
      miscompares++;
      $display("FAIL %s issue_count: got %0d, expected %0d", name, iss_q.size(), exp_iss.size());
    end
    for (int i = 0; i < iss_q.size() && i < exp_iss.size(); i++) begin
      vectors++;
      if ({iss_q[i].s, iss_q[i].z, iss_q[i].r, iss_q[i].sg, iss_q[i].dt} !==
          {exp_iss[i].s, exp_iss[i].z, exp_iss[i].r, exp_iss[i].sg, exp_iss[i].dt}) begin
        miscompares++;
        $display("FAIL %s issue[%0d]: got S=%h z=%h r=%h, expected S=%h z=%h r=%h", name, i,
                 iss_q[i].s, iss_q[i].z, iss_q[i].r, exp_iss[i].s, exp_iss[i].z, exp_iss[i].r);
      end
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d, expected 1", name, done_cnt);
    end
    vectors++;
    if (e_cap > 0 && done_cyc !== last_hs_cyc + 1) begin
      miscompares++;
      $display("FAIL %s done_timing: got cycle %0d, expected %0d", name, done_cyc, last_hs_cyc + 1);
    end else if (e_cap == 0 && done_cyc !== start_cyc) begin
      miscompares++;
      $display("FAIL %s done_timing: got cycle %0d, expected %0d", name, done_cyc, start_cyc);
    end
    vectors++;
    if ({busy, clamp_flag} !== {1'b0, exp_clamp}) begin
      miscompares++;
      $display("FAIL %s busy_clamp: got busy=%b clamp=%b, expected busy=0 clamp=%b",
               name, busy, clamp_flag, exp_clamp);
    end
    vectors++;
    if (z_hs !== e_cap) begin
      miscompares++;
      $display("FAIL %s z_handshakes: got %0d, expected %0d", name, z_hs, e_cap);
    end
  endtask

  task automatic set_path(logic [31:0] a, b, c, d, int n, int zmode, int force_step);
    e_s0 = a; e_r = b; e_sg = c; e_dt = d; e_n = n; e_force = force_step;
    z_ref.delete();
    for (int i = 0; i < n; i++)
      z_ref.push_back(zmode == 0 ? 32'd0 : 32'($urandom_range(0, 32'h0001_0000)) - 32'h0000_8000);
  endtask

  task automatic check_reset_outputs(string name);
    vectors++;
    if ({z_ready, gbm_valid, res_ready, out_valid, done, busy, clamp_flag, out_last} !== 8'd0) begin
      miscompares++;
      $display("FAIL %s ctrl: got %b, expected 00000000", name,
               {z_ready, gbm_valid, res_ready, out_valid, done, busy, clamp_flag, out_last});
    end
    vectors++;
    if ({gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt, out_S, out_step} !== '0) begin
      miscompares++;
      $display("FAIL %s data: got gbm_S=%h gbm_z=%h out_S=%h step=%0d, expected all 0",
               name, gbm_S, gbm_z, out_S, out_step);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    stall_pct = 0;
    set_path(32'h0064_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 4, 0, -1);
    start_path();
    finish_path("basic");
    basic_smp = smp_q;
  endtask

  task automatic test_stall();
    bit same;
    stall_pct = 30;
    set_path(32'h0064_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 4, 0, -1);
    start_path();
    finish_path("stall");
    same = (smp_q.size() == basic_smp.size());
    for (int i = 0; same && i < smp_q.size(); i++)
      if (smp_q[i] != basic_smp[i]) same = 0;
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL stall_vs_basic: got %0d samples differing from %0d unstalled samples",
               smp_q.size(), basic_smp.size());
    end
  endtask

  task automatic test_random();
    stall_pct = 30;
    for (int t = 0; t < 4; t++) begin
      set_path(32'h0010_0000 + 32'($urandom_range(0, 32'h00FF_FFFF)), 32'($urandom_range(0, 32'h2000)),
               32'($urandom_range(0, 32'h2000)), 32'($urandom_range(0, 32'h2000)),
               $urandom_range(1, 12), 1, -1);
      start_path();
      finish_path("random");
    end
  endtask

  task automatic test_clamp();
    stall_pct = 0;
    set_path(32'h0064_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_1000, 4, 0, 1);
    start_path();
    finish_path("clamp");
  endtask

  task automatic test_zero_steps();
    stall_pct = 0;
    set_path(32'h0064_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 0, 0, -1);
    start_path();
    finish_path("zero_steps");
    vectors++;
    if ({saw_z_ready, saw_out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_steps_idle: got z_ready_seen=%b out_valid_seen=%b, expected 0 0",
               saw_z_ready, saw_out_valid);
    end
  endtask

  task automatic test_max_steps();
    stall_pct = 0;
    set_path(32'h0064_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 300, 1, -1);
    start_path();
    finish_path("max_steps");
  endtask

  task automatic test_reset_mid();
    int w = 0;
    stall_pct = 0;
    set_path(32'h0064_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 5, 1, -1);
    start_path();
    @(negedge clk);
    while (!res_ready && w < 200) begin @(negedge clk); w++; end
    vectors++;
    if (!res_ready) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got res_ready=%b, expected 1", res_ready);
    end
    rst_n = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (smp_q.size() !== 0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_abandon: got %0d samples %0d done, expected 0 0", smp_q.size(), done_cnt);
    end
    set_path(32'h0050_0000, 32'h0000_0800, 32'h0000_1800, 32'h0000_0400, 2, 1, -1);
    start_path();
    finish_path("after_reset");
  endtask

  task automatic test_start_busy();
    stall_pct = 30;
    set_path(32'h0064_0000, 32'h0000_1000, 32'h0000_0800, 32'h0000_0400, 5, 1, -1);
    start_path();
    repeat (3) @(posedge clk);
    pulse_start(32'h0001_0000, 32'h1234_5678, 32'h0, 32'h0, 1);
    finish_path("start_busy");
  endtask

`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
  task automatic test_antithetic();
    stall_pct = 0;
    e_s0 = 32'h0064_0000; e_r = 32'h0000_1000; e_sg = 32'h0000_1000; e_dt = 32'h0000_1000;
    e_n = 3; e_force = -1;
    z_ref.delete();
    z_ref.push_back(32'h0001_0000); z_ref.push_back(32'h8000_0000); z_ref.push_back(32'h0);
    start_path();
    finish_path("antithetic");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_clamp();
    test_zero_steps();
    test_max_steps();
    test_reset_mid();
    test_start_busy();
`ifdef GBM_PATH_SEQ_ANTITHETIC_EN
    test_antithetic();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
